// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM states, bus-level constants and the default address.
// Pure declarations; no logic and no timing.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_t;

    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [6:0] DEF_I2C_ADDR = 7'h64;

endpackage

// File: rtl/i2c_line_filter.sv
// Pad synchroniser plus FILT_LEN-sample majority filter with registered level and edge strobes.
// Latency about 2+FILT_LEN clk from pad to filt; no backpressure, samples every clk.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [1:0]          sync;
    logic [FILT_LEN-1:0] win;
    logic                prev;
    logic [3:0]          ones;
    logic                vote;

    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < FILT_LEN; i++) begin
            ones = ones + 4'(win[i]);
        end
        vote = (ones > 4'(FILT_LEN / 2));
    end

    // Idle bus level is high, so everything presets to 1 to avoid a fake edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            win  <= '1;
            filt <= 1'b1;
            prev <= 1'b1;
        end else begin
            sync   <= {sync[0], line};
            win[0] <= sync[1];
            for (int i = 1; i < FILT_LEN; i++) begin
                win[i] <= win[i-1];
            end
            filt <= vote;
            prev <= filt;
        end
    end

    assign rise = filt & ~prev;
    assign fall = ~filt & prev;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C register target: NUM_REGS byte registers, auto-incrementing pointer, one-cycle write strobe.
// Bus latency 2+FILT_LEN clk; SCL-low timeout release only when I2C_TIMEOUT_EN is defined.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR    = DEF_I2C_ADDR,
    parameter int          NUM_REGS    = 4,
    parameter int          FILT_LEN    = 3,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        sda_oe,
    input  logic [NUM_REGS*8-1:0]       rd_regs,
    output logic                        wr_en,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic [7:0]                  wr_data,
    output logic                        busy,
    output logic                        timeout
);

    localparam int         PW    = $clog2(NUM_REGS);
    localparam logic [7:0] NREG8 = 8'(NUM_REGS);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (scl_in),
        .filt  (scl_f),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (sda_in),
        .filt  (sda_f),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_t    state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    tx, tx_n;
    logic [PW-1:0] ptr, ptr_n, ptr_inc, rd_sel;
    logic          rw, rw_n;
    logic          mack, mack_n;
    logic          oe_n, busy_n, wr_en_n, timeout_n;
    logic [PW-1:0] wr_addr_n;
    logic [7:0]    wr_data_n;
    logic [7:0]    byte_in, rd_byte;
    logic          start_c, stop_c, to_hit;

    assign start_c = sda_fall & scl_f;
    assign stop_c  = sda_rise & scl_f;
    assign byte_in = {shreg[6:0], sda_f};
    assign ptr_inc = (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
    // Next read byte comes from the incremented pointer when a controller ACK continues the burst.
    assign rd_sel  = (state == ST_RDATA_ACK) ? ptr_inc : ptr;
    assign rd_byte = rd_regs[{rd_sel, 3'b000} +: 8];

`ifdef I2C_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= 16'd0;
        end else if (!busy || scl_f) begin
            to_cnt <= 16'd0;
        end else if (to_cnt != 16'hFFFF) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign to_hit = busy & ~scl_f & (to_cnt >= TIMEOUT_CYC);
`else
    // Feature compiled out; the parameter stays for a uniform instantiation interface.
    assign to_hit = 1'b0 & (TIMEOUT_CYC != 16'd0);
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        tx_n      = tx;
        ptr_n     = ptr;
        rw_n      = rw;
        mack_n    = mack;
        oe_n      = sda_oe;
        busy_n    = busy;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        timeout_n = 1'b0;

        if (to_hit) begin
            state_n   = ST_IDLE;
            oe_n      = 1'b0;
            busy_n    = 1'b0;
            timeout_n = 1'b1;
        end else if (stop_c) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_c) begin
            state_n = ST_ADDR;
            cnt_n   = 3'd0;
            oe_n    = 1'b0;
        end else if (scl_rise) begin
            shreg_n = byte_in;
            cnt_n   = cnt + 3'd1;
            case (state)
                ST_ADDR: if (cnt == 3'd7) begin
                    cnt_n = 3'd0;
                    if (byte_in[7:1] == I2C_ADDR) begin
                        state_n = ST_ADDR_ACK;
                        busy_n  = 1'b1;
                        rw_n    = byte_in[0];
                    end else begin
                        state_n = ST_IGNORE;
                    end
                end
                ST_PTR: if (cnt == 3'd7) begin
                    cnt_n = 3'd0;
                    if (byte_in < NREG8) begin
                        ptr_n   = byte_in[PW-1:0];
                        state_n = ST_PTR_ACK;
                    end else begin
                        oe_n    = ~BIT_NACK;
                        state_n = ST_IGNORE;
                    end
                end
                ST_WDATA: if (cnt == 3'd7) begin
                    cnt_n     = 3'd0;
                    wr_en_n   = 1'b1;
                    wr_addr_n = ptr;
                    wr_data_n = byte_in;
                    state_n   = ST_WDATA_ACK;
                end
                ST_RDATA: if (cnt == 3'd7) begin
                    cnt_n   = 3'd0;
                    state_n = ST_RDATA_ACK;
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: cnt_n = 3'd1;
                ST_RDATA_ACK: begin
                    cnt_n  = 3'd1;
                    mack_n = sda_f;
                end
                default: cnt_n = cnt;
            endcase
        end else if (scl_fall) begin
            // ACK states: cnt==0 means the ninth clock is starting, cnt==1 means it just ended.
            case (state)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (cnt == 3'd0) begin
                        oe_n = ~BIT_ACK;
                    end else begin
                        oe_n  = 1'b0;
                        cnt_n = 3'd0;
                        if (state == ST_ADDR_ACK && rw == RW_READ) begin
                            tx_n    = rd_byte;
                            oe_n    = ~rd_byte[7];
                            state_n = ST_RDATA;
                        end else if (state == ST_ADDR_ACK) begin
                            state_n = ST_PTR;
                        end else begin
                            if (state == ST_WDATA_ACK) begin
                                ptr_n = ptr_inc;
                            end
                            state_n = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: oe_n = ~tx[3'd7 - cnt];
                ST_RDATA_ACK: begin
                    if (cnt == 3'd0) begin
                        oe_n = 1'b0;
                    end else if (mack == BIT_ACK) begin
                        ptr_n   = ptr_inc;
                        tx_n    = rd_byte;
                        oe_n    = ~rd_byte[7];
                        cnt_n   = 3'd0;
                        state_n = ST_RDATA;
                    end else begin
                        state_n = ST_IGNORE;
                    end
                end
                default: oe_n = sda_oe;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            shreg   <= 8'd0;
            tx      <= 8'd0;
            ptr     <= '0;
            rw      <= RW_WRITE;
            mack    <= BIT_NACK;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'd0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            ptr     <= ptr_n;
            rw      <= rw_n;
            mack    <= mack_n;
            sda_oe  <= oe_n;
            busy    <= busy_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged controller on an open-drain SDA model.
// Timeout scenario runs when compiled with I2C_TIMEOUT_EN (TIMEOUT_CYC=100).
module tb_i2c_reg_target;

    localparam int NR = 4;
    localparam int Q  = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_oe, wr_en, busy, timeout;
    logic [1:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [NR*8-1:0] rd_regs = 32'h4433_2211;
    wire           sda_line = sda_m & ~sda_oe;

    int total = 0;
    int bad   = 0;
    logic [15:0] wlog[$];
    int oe_hi = 0, busy_hi = 0, to_hi = 0;

    i2c_reg_target #(
        .I2C_ADDR    (7'h64),
        .NUM_REGS    (NR),
        .FILT_LEN    (3),
        .TIMEOUT_CYC (16'd100)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl_m),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .rd_regs (rd_regs),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en)   wlog.push_back({6'd0, wr_addr, wr_data});
        if (sda_oe)  oe_hi++;
        if (busy)    busy_hi++;
        if (timeout) to_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wl(input int i);
        return (i < wlog.size()) ? wlog[i] : 16'hFFFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wlog.delete();
        oe_hi   = 0;
        busy_hi = 0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(Q);
            scl_m = 1'b1; tick(2 * Q);
            scl_m = 1'b0; tick(Q);
            if (glitch && i == 4) begin
                scl_m = 1'b1; tick(1);
                scl_m = 1'b0; tick(Q);
            end
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        ack = sda_line;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            scl_m = 1'b1; tick(Q);
            b[i] = sda_line;
            tick(Q);
            scl_m = 1'b0;
        end
        tick(Q);
        sda_m = mack; tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
        sda_m = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;

        tick(5);
        check("rst_sda_oe",  sda_oe,  0);
        check("rst_wr_en",   wr_en,   0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy",    busy,    0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        tick(20);

        // write two bytes from pointer 1
        clear_mon();
        i2c_start();
        send_byte(8'hC8, 0, ack); check("wr_addr_ack", ack, 0);
        check("wr_busy_set", busy, 1);
        send_byte(8'h01, 0, ack); check("wr_ptr_ack", ack, 0);
        send_byte(8'hA5, 0, ack); check("wr_d0_ack", ack, 0);
        send_byte(8'h3C, 0, ack); check("wr_d1_ack", ack, 0);
        i2c_stop(); tick(20);
        check("wr_count", wlog.size(), 2);
        check("wr_first", wl(0), 16'h01A5);
        check("wr_second", wl(1), 16'h023C);
        check("wr_busy_clr", busy, 0);

        // pointer 3, repeated start, burst read wraps to 0
        clear_mon();
        i2c_start();
        send_byte(8'hC8, 0, ack);
        send_byte(8'h03, 0, ack); check("rd_ptr_ack", ack, 0);
        i2c_rstart();
        send_byte(8'hC9, 0, ack); check("rd_addr_ack", ack, 0);
        read_byte(1'b0, rb); check("rd_b0", rb, 8'h44);
        read_byte(1'b0, rb); check("rd_b1_wrap", rb, 8'h11);
        read_byte(1'b1, rb); check("rd_b2", rb, 8'h22);
        i2c_stop(); tick(20);
        check("rd_no_write", wlog.size(), 0);
        check("rd_busy_clr", busy, 0);

        // foreign address
        clear_mon();
        i2c_start();
        send_byte(8'hAA, 0, ack); check("mm_nack", ack, 1);
        send_byte(8'hFF, 0, ack);
        i2c_stop(); tick(20);
        check("mm_oe_never", oe_hi, 0);
        check("mm_no_write", wlog.size(), 0);
        check("mm_busy_never", busy_hi, 0);

        // out-of-range pointer leaves pointer at 1
        clear_mon();
        i2c_start();
        send_byte(8'hC8, 0, ack); check("bp_addr_ack", ack, 0);
        send_byte(8'h07, 0, ack); check("bp_ptr_nack", ack, 1);
        send_byte(8'h5A, 0, ack); check("bp_data_nack", ack, 1);
        i2c_stop(); tick(20);
        check("bp_no_write", wlog.size(), 0);
        i2c_start();
        send_byte(8'hC9, 0, ack);
        read_byte(1'b1, rb); check("bp_ptr_kept", rb, 8'h22);
        i2c_stop(); tick(20);

        // one-clk SCL glitch inside the pointer byte must not count
        clear_mon();
        i2c_start();
        send_byte(8'hC8, 0, ack);
        send_byte(8'h02, 1, ack); check("gl_ptr_ack", ack, 0);
        send_byte(8'h77, 0, ack); check("gl_data_ack", ack, 0);
        i2c_stop(); tick(20);
        check("gl_count", wlog.size(), 1);
        check("gl_write", wl(0), 16'h0277);

        // reset in the middle of a read (pointer 3 -> 0x44, MSB 0 driven low)
        clear_mon();
        i2c_start();
        send_byte(8'hC9, 0, ack);
        check("rs_driving", sda_oe, 1);
        rst_n = 1'b0; #1;
        check("rs_oe_async", sda_oe, 0);
        check("rs_busy", busy, 0);
        tick(3);
        rst_n = 1'b1;
        scl_m = 1'b1; sda_m = 1'b1;
        tick(20);
        i2c_start();
        send_byte(8'hC9, 0, ack); check("rs_addr_ack", ack, 0);
        read_byte(1'b1, rb); check("rs_ptr_zero", rb, 8'h11);
        i2c_stop(); tick(20);
        check("rs_no_write", wlog.size(), 0);

`ifdef I2C_TIMEOUT_EN
        to_hi = 0;
        i2c_start();
        send_byte(8'hC9, 0, ack);
        check("to_driving", sda_oe, 1);
        tick(130);
        check("to_pulse", to_hi, 1);
        check("to_oe", sda_oe, 0);
        check("to_busy", busy, 0);
        scl_m = 1'b1; tick(20);
`else
        check("to_never", to_hi, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
Parametrised successor to the fixed read-only I2C slave. Implements an oversampled I2C target with NUM_REGS byte registers, a register pointer with auto-increment and wrap, and write support through a one-cycle write strobe. Sits between the SCL/SDA pads (open-drain, uio pins) and the position/status logic in the top level.

Parameters:
I2C_ADDR, 7'h64, 7-bit target address.
NUM_REGS, 4, number of byte registers readable and writable (2..16).
FILT_LEN, 3, glitch-filter depth in clk samples (odd, 1..7); majority vote.
TIMEOUT_CYC, 16'd50000, SCL-low clk cycles before bus release (only with I2C_TIMEOUT_EN).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
scl_in  input  1  SCL pad level
sda_in  input  1  SDA pad level
sda_oe  output  1  1 = pull SDA low, 0 = release (pad data tied 0 externally)
rd_regs  input  NUM_REGS*8  packed read values; reg k = bits [8k+7:8k]
wr_en  output  1  one-cycle write strobe
wr_addr  output  $clog2(NUM_REGS)  register index for wr_data
wr_data  output  8  byte written by controller
busy  output  1  high from addressed START until STOP/abort
timeout  output  1  one-cycle pulse on SCL-low timeout (0 when feature off)

Behaviour:
- Reset: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, timeout=0, FSM=IDLE, pointer=0, filters preset to 1.
- Input path: 2-flop synchroniser, then FILT_LEN majority filter per line. Edge/condition detection on filtered signals; total input latency 2+FILT_LEN clk.
- START: filtered SDA falls while SCL high. STOP: SDA rises while SCL high. Both are valid in every state, including mid-byte.
- STOP -> IDLE, sda_oe=0, busy=0. START (including repeated) -> ADDR, bit counter=0.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Bits are sampled on SCL rise. sda_oe changes only on SCL fall, one clk after detection.
- ADDR: after 8 bits, addr match -> ADDR_ACK (drive 0 for the 9th clock) and busy=1. Mismatch -> IGNORE until START/STOP.
- R/W=0 -> PTR. First data byte is the pointer. Pointer < NUM_REGS -> ACK, load pointer, go to WDATA. Otherwise NACK -> IGNORE.
- WDATA: on the 8th SCL rise, wr_en=1 for one clk with wr_addr=pointer and wr_data=byte. ACK, then pointer = (pointer+1) mod NUM_REGS.
- R/W=1 -> RDATA from current pointer. The byte is snapshotted from rd_regs at the SCL fall that ends the preceding ACK, so it is stable through the transfer.
- RDATA: MSB first; for each bit, sda_oe = ~bit. Release SDA after the 8th bit. In RDATA_ACK, sample the controller: ACK -> pointer++ (wrap) and next byte; NACK -> IGNORE.
- Pointer persists across transactions, so write-pointer-then-repeated-START-read works. Reset only clears it.
- wr_en never asserts in read transactions, on address mismatch, or on NACKed pointer.
- Reset mid-transfer aborts immediately. No spurious write; sda_oe=0 asynchronously.

Optional Feature:
I2C_TIMEOUT_EN defined:
- 16-bit counter runs while busy=1 and filtered SCL is low; cleared on any SCL high.
- Reaching TIMEOUT_CYC forces IDLE, sda_oe=0, busy=0, and pulses timeout for one clk.

Undefined: no counter; timeout tied 0; TIMEOUT_CYC unused.

Decomposition:
- Package i2c_pkg: FSM state enum, ACK/NACK constants, R/W bit constants, default address.
- Sub-module i2c_line_filter (synchroniser + majority filter + rise/fall outputs), instantiated twice (SCL, SDA).
- FSM, shift register and pointer stay in i2c_reg_target.

Test Plan:
- Write: addr 0x64+W, ptr 0x01, data 0xA5, 0x3C, STOP -> wr_en pulses twice with (1,0xA5) then (2,0x3C); all ACKed; busy falls after STOP.
- Read with wrap: rd_regs={0x44,0x33,0x22,0x11}; write ptr 0x03, repeated START, 0x64+R, read 3 bytes (ACK, ACK, NACK) -> bytes 0x44, 0x11, 0x22; no wr_en.
- Mismatch: addr 0x55+W, data 0xFF -> sda_oe never 1, no wr_en, busy stays 0.
- Bad pointer: addr 0x64+W, ptr 0x07 (NUM_REGS=4) -> pointer byte NACKed, following data ignored, pointer unchanged.
- Glitch/reset: 1-clk SCL pulse during a byte -> no bit counted. Assert rst_n mid-read -> sda_oe=0 at once; next read from ptr 0.
- I2C_TIMEOUT_EN with TIMEOUT_CYC=100: hold SCL low 100 clk mid-read -> timeout pulse, sda_oe=0, busy=0.
